// File: rtl/ddc_edid_responder_if.sv
// DDC/EDID target bus bundle: open-drain SCL/SDA pair, EDID ROM read port and status.
interface ddc_edid_responder_if;
  logic       scl_input;
  logic       scl_output;
  logic       sda_input;
  logic       sda_output;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic       active;
  logic       byte_read;

  modport master (
    output scl_input, sda_input, rom_data,
    input  scl_output, sda_output, rom_address, active, byte_read
  );

  modport slave (
    input  scl_input, sda_input, rom_data,
    output scl_output, sda_output, rom_address, active, byte_read
  );
endinterface

// File: rtl/ddc_edid_responder.sv
// I2C/DDC target serving a 256-byte EDID image from an external synchronous ROM.
// Inputs are synchronized and glitch-filtered; SDA only changes after a filtered SCL fall.
module ddc_edid_responder #(
  parameter logic [6:0]  DEVICE_ADDRESS = 7'h50,
  parameter int unsigned FILTER_LENGTH  = 4
) (
  input logic                 system_clock,
  input logic                 system_reset,
  ddc_edid_responder_if.slave bus
);

  localparam int unsigned      CNT_W    = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDRESS,
    S_ADDR_ACK,
    S_OFFSET,
    S_OFFSET_ACK,
    S_WRITE_EXTRA,
    S_READ_DATA,
    S_READ_ACK,
    S_IGNORE
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       filt;
  logic [1:0]       filt_q;
  logic [CNT_W-1:0] cnt [2];

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bitcnt;
  logic       rw;
  logic       ack_on;
  logic       acked;
  logic [7:0] pointer;
  logic       sda_drive;
  logic       active_q;
  logic       byte_read_q;

  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;

  // Synchronizer plus run-length filter; everything presets to the idle-bus level.
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      meta   <= 2'b11;
      sync   <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      meta   <= {bus.sda_input, bus.scl_input};
      sync   <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign start_c  = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
  assign stop_c   = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

  // Protocol FSM; START/STOP override every state.
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      rw          <= 1'b0;
      ack_on      <= 1'b0;
      acked       <= 1'b0;
      pointer     <= '0;
      sda_drive   <= 1'b1;
      active_q    <= 1'b0;
      byte_read_q <= 1'b0;
    end else begin
      byte_read_q <= 1'b0;
      if (stop_c) begin
        state     <= S_IDLE;
        sda_drive <= 1'b1;
        active_q  <= 1'b0;
      end else if (start_c) begin
        state     <= S_ADDRESS;
        bitcnt    <= '0;
        sda_drive <= 1'b1;
        active_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;

          S_ADDRESS: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                if (shreg[6:0] == DEVICE_ADDRESS) begin
                  state    <= S_ADDR_ACK;
                  rw       <= sda_f;
                  ack_on   <= 1'b0;
                  active_q <= 1'b1;
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          // First fall after the byte starts the ACK, the next fall ends it.
          S_ADDR_ACK, S_OFFSET_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on    <= 1'b1;
                sda_drive <= 1'b0;
              end else begin
                ack_on <= 1'b0;
                if (state == S_OFFSET_ACK) begin
                  sda_drive <= 1'b1;
                  state     <= S_WRITE_EXTRA;
                end else if (!rw) begin
                  sda_drive <= 1'b1;
                  bitcnt    <= '0;
                  state     <= S_OFFSET;
                end else begin
                  sda_drive <= bus.rom_data[7];
                  shreg     <= {bus.rom_data[6:0], 1'b0};
                  bitcnt    <= 4'd1;
                  state     <= S_READ_DATA;
                end
              end
            end
          end

          S_OFFSET: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              if (bitcnt == 4'd7) begin
                bitcnt  <= '0;
                pointer <= {shreg[6:0], sda_f};
                ack_on  <= 1'b0;
                state   <= S_OFFSET_ACK;
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          // Extra write bytes are clocked past with SDA released, which NACKs them.
          S_WRITE_EXTRA: ;

          S_READ_DATA: begin
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_drive   <= 1'b1;
                byte_read_q <= 1'b1;
                acked       <= 1'b0;
                state       <= S_READ_ACK;
              end else begin
                sda_drive <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
                bitcnt    <= bitcnt + 4'd1;
              end
            end
          end

          // rom_address moves on the ACK rise, leaving half an SCL period for the ROM.
          S_READ_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                acked   <= 1'b1;
                pointer <= pointer + 8'd1;
              end else begin
                active_q <= 1'b0;
                state    <= S_IGNORE;
              end
            end else if (scl_fall && acked) begin
              acked     <= 1'b0;
              sda_drive <= bus.rom_data[7];
              shreg     <= {bus.rom_data[6:0], 1'b0};
              bitcnt    <= 4'd1;
              state     <= S_READ_DATA;
            end
          end

          S_IGNORE: sda_drive <= 1'b1;

          default: begin
            state     <= S_IDLE;
            sda_drive <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.scl_output  = 1'b1;
  assign bus.sda_output  = sda_drive;
  assign bus.rom_address = pointer;
  assign bus.active      = active_q;
  assign bus.byte_read   = byte_read_q;

  logic unused_scl_f;
  assign unused_scl_f = scl_f;

endmodule
